// File: rtl/mm_drain_pkg.sv
// rtl/mm_drain_pkg.sv - state type and width helpers for the GEMM result drain
package mm_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

  function automatic int row_idx_w(input int row_num);
    return (row_num <= 1) ? 1 : $clog2(row_num);
  endfunction

  // Counter holds CORE_LATENCY-1 at most.
  function automatic int lat_cnt_w(input int core_latency);
    return (core_latency <= 1) ? 1 : $clog2(core_latency);
  endfunction

endpackage

// File: rtl/mm_res_drain.sv
// rtl/mm_res_drain.sv - captures the GEMM array result after its pipeline latency
// and streams it out one row per valid/ready beat
module mm_res_drain
  import mm_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ROW_NUM      = 8,
  parameter int COL_NUM      = 8,
  parameter int CORE_LATENCY = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_valid,
  output logic                                  start_ready,
  input  logic [DATA_WIDTH*ROW_NUM*COL_NUM-1:0] res,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH*COL_NUM-1:0]         out_data,
  output logic [row_idx_w(ROW_NUM)-1:0]         out_row,
  output logic                                  out_last
);

  localparam int RW     = row_idx_w(ROW_NUM);
  localparam int LW     = lat_cnt_w(CORE_LATENCY);
  localparam int ROW_W  = DATA_WIDTH * COL_NUM;
  localparam int TILE_W = ROW_W * ROW_NUM;

  drain_state_e             state, state_nxt;
  logic [LW-1:0]            lat_cnt;
  logic [RW-1:0]            row_idx;
  logic [TILE_W-1:0]        capture;
  logic [ROW_NUM-1:0][ROW_W-1:0] row_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (row_idx == RW'(ROW_NUM - 1));
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // res is sampled only on the terminal WAIT cycle; later changes never reach the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
      row_idx <= '0;
      capture <= '0;
    end else begin
      if (state == IDLE && start_valid) begin
        lat_cnt <= LW'(CORE_LATENCY - 1);
      end else if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (state == WAIT && lat_cnt == '0) begin
        capture <= res;
        row_idx <= '0;
      end
      if (state == DRAIN && out_ready) begin
        row_idx <= out_last ? '0 : row_idx + 1'b1;
      end
    end
  end

  genvar r;
  generate
    for (r = 0; r < ROW_NUM; r++) begin : g_row_sel
      assign row_sel[r] = (row_idx == RW'(r)) ? capture[r*ROW_W +: ROW_W] : '0;
    end
  endgenerate

  always_comb begin
    out_data = '0;
    for (int i = 0; i < ROW_NUM; i++) begin
      out_data = out_data | row_sel[i];
    end
  end

  assign out_row = row_idx;

endmodule

// File: tb/tb_mm_res_drain.sv
// tb/tb_mm_res_drain.sv - randomized self-checking bench for mm_res_drain
module tb_mm_res_drain;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid, start_ready;
  logic [31:0] res;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;
  logic [0:0]  out_row;

  logic        sv1, sr1, ov1, or1, ol1;
  logic [15:0] res1, od1;
  logic [0:0]  orow1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_res_drain #(.DATA_WIDTH(8), .ROW_NUM(2), .COL_NUM(2), .CORE_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .res(res), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last)
  );

  mm_res_drain #(.DATA_WIDTH(8), .ROW_NUM(1), .COL_NUM(2), .CORE_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(sr1),
    .res(res1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_row(orow1), .out_last(ol1)
  );

  // Reference: row r of a tile is the 16-bit slice holding elements (r,0) and (r,1).
  function automatic logic [15:0] row_of(input logic [31:0] tile, input int r);
    return tile[r*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_valid = 0; out_ready = 0; res = '0;
    sv1 = 0; or1 = 0; res1 = '0;
    tick(); tick();
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_row !== 1'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b last=%b row=%0d data=%h required 1 0 0 0 0000",
               start_ready, out_valid, out_last, out_row, out_data);
    end
    checks++;
    if (sr1 !== 1'b1 || ov1 !== 1'b0 || ol1 !== 1'b0 || od1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state_r1: ready=%b valid=%b last=%b data=%h required 1 0 0 0000",
               sr1, ov1, ol1, od1);
    end
    reset = 1'b1;
    tick();
  endtask

  // Each tile: res carries garbage except in the single cycle feeding edge T+L.
  task automatic test_basic(input int ntiles);
    logic [31:0] tile;
    for (int k = 0; k < ntiles; k++) begin
      tile = (k == 0) ? 32'h44332211 : $urandom;
      out_ready = 1'b1;
      checks++;
      if (start_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_idle_ready: start_ready=%b required 1", start_ready);
      end
      start_valid = 1'b1;
      res = 32'hAAAAAAAA;
      tick();
      start_valid = 1'b0;
      for (int j = 0; j < L; j++) begin
        checks++;
        if (out_valid !== 1'b0 || start_ready !== 1'b0) begin
          errors++;
          $display("FAIL basic_wait: cycle %0d valid=%b start_ready=%b required 0 0",
                   j, out_valid, start_ready);
        end
        res = (j == L - 1) ? tile : 32'hAAAAAAAA;
        tick();
      end
      res = 32'hFFFFFFFF;
      for (int r = 0; r < 2; r++) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== row_of(tile, r) || out_row !== 1'(r) ||
            out_last !== (r == 1)) begin
          errors++;
          $display("FAIL basic_beat%0d: valid=%b data=%h row=%0d last=%b required 1 %h %0d %b",
                   r, out_valid, out_data, out_row, out_last, row_of(tile, r), r, (r == 1));
        end
        tick();
      end
      checks++;
      if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_return: valid=%b start_ready=%b required 0 1", out_valid, start_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] tile;
    int r, n;
    for (int k = 0; k < 5; k++) begin
      tile = (k == 0) ? 32'h44332211 : $urandom;
      res = tile; out_ready = 1'b0; start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        tick(); n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_timeout: out_valid=%b required 1 within 20 cycles", out_valid);
      end
      r = 0; n = 0;
      while (r < 2 && n < 100) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== row_of(tile, r) || out_row !== 1'(r) ||
            out_last !== (r == 1)) begin
          errors++;
          $display("FAIL bp_beat%0d: cycle %0d valid=%b data=%h row=%0d last=%b required 1 %h %0d %b",
                   r, n, out_valid, out_data, out_row, out_last, row_of(tile, r), r, (r == 1));
        end
        out_ready = (k == 0) ? (n >= 5) : 1'($urandom_range(0, 1));
        tick();
        if (out_ready) r++;
        n++;
      end
      checks++;
      if (out_valid !== 1'b0 || r != 2) begin
        errors++;
        $display("FAIL bp_end: valid=%b beats=%0d required 0 2", out_valid, r);
      end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_busy_stall();
    logic [31:0] tile;
    int accepted, beats;
    tile = $urandom;
    res = tile; out_ready = 1'b1; start_valid = 1'b1;
    tick();
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (start_ready !== (c == 5)) begin
        errors++;
        $display("FAIL busy_ready: cycle %0d start_ready=%b required %b", c, start_ready, (c == 5));
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== row_of(tile, c - 3)) begin
          errors++;
          $display("FAIL busy_beat: valid=%b data=%h required 1 %h", out_valid, out_data,
                   row_of(tile, c - 3));
        end
      end
      if (start_valid && start_ready) accepted++;
      tick();
    end
    start_valid = 1'b0;
    checks++;
    if (accepted != 1 || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_accept: accepted=%0d start_ready=%b required 1 0", accepted, start_ready);
    end
    beats = 0;
    for (int n = 0; n < 12; n++) begin
      if (out_valid === 1'b1) beats++;
      tick();
    end
    checks++;
    if (beats != 2 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_second_tile: beats=%0d start_ready=%b required 2 1", beats, start_ready);
    end
  endtask

  task automatic test_reset_mid();
    res = $urandom; out_ready = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (L + 2) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: out_valid=%b required 1", out_valid);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b1 || out_last !== 1'b0 ||
        out_row !== 1'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL rst_async: valid=%b ready=%b last=%b row=%0d data=%h required 0 1 0 0 0000",
               out_valid, start_ready, out_last, out_row, out_data);
    end
    #2 reset = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_stale: cycle %0d valid=%b ready=%b required 0 1", n, out_valid, start_ready);
      end
    end
    test_basic(2);
  endtask

  task automatic test_single_row();
    logic [15:0] tile;
    for (int k = 0; k < 4; k++) begin
      tile = (k == 0) ? 16'hBEEF : 16'($urandom);
      res1 = tile; or1 = 1'b1; sv1 = 1'b1;
      checks++;
      if (sr1 !== 1'b1) begin
        errors++;
        $display("FAIL r1_idle: start_ready=%b required 1", sr1);
      end
      tick();
      sv1 = 1'b0;
      checks++;
      if (ov1 !== 1'b0 || sr1 !== 1'b0) begin
        errors++;
        $display("FAIL r1_wait: valid=%b ready=%b required 0 0", ov1, sr1);
      end
      tick();
      res1 = 16'h0000;
      checks++;
      if (ov1 !== 1'b1 || od1 !== tile || ol1 !== 1'b1 || orow1 !== 1'b0) begin
        errors++;
        $display("FAIL r1_beat: valid=%b data=%h last=%b row=%0d required 1 %h 1 0",
                 ov1, od1, ol1, orow1, tile);
      end
      tick();
      checks++;
      if (ov1 !== 1'b0 || sr1 !== 1'b1) begin
        errors++;
        $display("FAIL r1_return: valid=%b ready=%b required 0 1", ov1, sr1);
      end
    end
    or1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic(6);
    test_backpressure();
    test_busy_stall();
    test_reset_mid();
    test_single_row();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
